dht11_responder: RTL
====================

# dht11_responder

Single-wire DHT11 sensor emulator: the responder end of the DHT11 bus protocol. It detects a host start pulse on the shared open-drain `Data` line and answers with the acknowledge preamble and a 40-bit frame: humidity, temperature and checksum, MSB first. It sits beside the DHT11 reader in the air-conditioning design for hardware-in-the-loop bring-up. It also serves as the sensor model in reader testbenches.

## Interface
- `CLKS_PER_US`, 125, `clk_125M` cycles per microsecond tick.
- `START_MIN_US`, 18000, minimum host low pulse (µs) accepted as a start request.
- `RESP_DELAY_US`, 30, bus-release-to-acknowledge delay (µs).
- `ACK_US`, 80, duration of each acknowledge phase (low, then released).
- `BIT_LOW_US`, 50, low preamble before every data bit and after the last bit.
- `ZERO_HIGH_US`, 26, released duration encoding a 0.
- `ONE_HIGH_US`, 70, released duration encoding a 1.
- `clk_125M` in 1: system clock. Only clock in the block.
- `nRST` in 1: reset, asynchronous and active-low.
- `Data` inout 1: open-drain DHT11 bus, externally pulled up. The block drives only `0` or `z`.
- `humid_int`, `humid_dec`, `temp_int`, `temp_dec` in 8 each: frame payload values.
- `cksum_err_inj` in 1: when high at snapshot, the transmitted checksum is bit-inverted.
- `busy` out 1: high from start acceptance until the end of the frame.
- `frame_done` out 1: one-cycle pulse when the final low preamble ends.

## Operation
- `Data` is sampled through a 2-FF synchronizer into `din`. All decisions use `din`.
- Bus drive: internal `drive_low`. `Data = drive_low ? 0 : z`. The block never drives 1.
- µs prescaler: counts 0..CLKS_PER_US-1 and emits a tick. It restarts at 0 on every state change, so a phase of N µs lasts exactly N×CLKS_PER_US cycles.
- Phase counter: 16-bit, counts ticks, saturates at 0xFFFF.
- States and transitions:
  - IDLE: line released. `din`=0 → START_LOW with the counter cleared.
  - START_LOW: line released, measuring the host low.
    - `din`=1 with count ≥ START_MIN_US → snapshot payload, go to RESP_DLY.
    - `din`=1 with count < START_MIN_US → IDLE. The pulse is treated as a glitch with no response.
  - RESP_DLY: line released for RESP_DELAY_US → ACK_LOW.
  - ACK_LOW: drive low for ACK_US → ACK_HIGH.
  - ACK_HIGH: release for ACK_US → BIT_LOW, with bit index 39.
  - BIT_LOW: drive low for BIT_LOW_US.
    - Bit index ≥ 0 → BIT_HIGH.
    - Bit index = −1 (all 40 bits sent) → DONE.
  - BIT_HIGH: release for ZERO_HIGH_US or ONE_HIGH_US, chosen by `shreg[39]`. Then shift left, decrement the index, → BIT_LOW.
  - DONE: pulse `frame_done` for one cycle, release the line → IDLE.
- Snapshot: a 40-bit `shreg` is loaded as {humid_int, humid_dec, temp_int, temp_dec, cksum}.
  - `cksum` = 8-bit sum of the four bytes, modulo 256 (carry discarded).
  - If `cksum_err_inj`=1, `cksum` is inverted.
  - Payload inputs may change freely after the snapshot without affecting the frame in flight.
- `busy` = 1 in RESP_DLY through DONE, and 0 in IDLE and START_LOW.
- From RESP_DLY onward, `din` is ignored. Host activity cannot abort a frame; only `nRST` can.
- A new start request is accepted only after returning to IDLE.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - State IDLE, `drive_low`=0 (`Data`=z), `busy`=0, `frame_done`=0.
  - Counters and `shreg` cleared, synchronizer flops set to 1.
- Reset asserted mid-frame releases the bus on the same edge, with no further output.
- Start detection latency: 2 cycles of synchronizer, plus 1 cycle to enter RESP_DLY after the rising edge.
- Response timeline after the host release is seen (µs): 30 released, 80 low, 80 released. Then 40 × (50 low + 26/70 released), then 50 low, then release.
- Frame length with N ones:
  - 30 + 160 + 40×50 + (40−N)×26 + N×70 + 50 µs
  - = 3280 + 44N µs.
- A host low pulse exactly START_MIN_US ticks long is accepted. One tick shorter is rejected.
- A host low held longer than 65535 µs is still accepted: the counter saturates.

## Test plan
- Payload H=0x37, 0x00, T=0x19, 0x00. Host low 19000 µs, then release → after 30 µs, ACK 80/80. Bits decode to 0x37 00 19 00 50. `frame_done` pulses once. `busy` falls with it.
- Host low 17999 µs with START_MIN_US=18000 → bus never driven, `busy` stays 0. A following 18000 µs pulse → normal frame.
- Payload 0xFF,0xFF,0xFF,0xFF → checksum 0xFC (carry dropped). The frame is all ones except the checksum bits 1,0 = 0. Measured frame time matches 3280+44N µs with N=38.
- `cksum_err_inj`=1 with payload 0x37,0x00,0x19,0x00 → checksum byte 0xAF. The other bytes are unchanged.
- Payload changed during the response and the host pulls the line low mid-frame → transmitted bytes equal the snapshot, and timing is unaffected.
- `nRST` asserted during bit 20 → `Data`=z, `busy`=0 immediately. After release, the next valid start yields a complete, correct frame.

Source files
------------

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: detects a host start pulse on the open-drain Data line
// and answers with the acknowledge preamble plus a 40-bit humidity/temperature frame.
module dht11_responder #(
  parameter int unsigned CLKS_PER_US   = 125,
  parameter int unsigned START_MIN_US  = 18000,
  parameter int unsigned RESP_DELAY_US = 30,
  parameter int unsigned ACK_US        = 80,
  parameter int unsigned BIT_LOW_US    = 50,
  parameter int unsigned ZERO_HIGH_US  = 26,
  parameter int unsigned ONE_HIGH_US   = 70
) (
  input  logic       clk_125M,
  input  logic       nRST,
  inout  wire        Data,
  input  logic [7:0] humid_int,
  input  logic [7:0] humid_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  input  logic       cksum_err_inj,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  // The IDLE cycle that first sees din=0 already belongs to the host pulse.
  localparam logic [PW-1:0] SEED_PRE = (CLKS_PER_US > 1) ? PW'(1) : '0;
  localparam logic [15:0]   SEED_CNT = (CLKS_PER_US > 1) ? 16'd0 : 16'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_START_LOW, S_RESP_DLY, S_ACK_LOW,
    S_ACK_HIGH, S_BIT_LOW, S_BIT_HIGH, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [39:0]   shreg_q, shreg_d;
  logic [5:0]    idx_q, idx_d;
  logic          drive_low_q, drive_low_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          din_s;
  logic          tick_s;
  logic [15:0]   high_last_s;

  function automatic logic [7:0] calc_cksum(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input logic [7:0] d,
                                            input logic inj);
    logic [7:0] sum;
    sum = a + b + c + d;
    return inj ? ~sum : sum;
  endfunction

  assign din_s       = sync_q[1];
  assign tick_s      = (pre_q == PW'(CLKS_PER_US - 1));
  assign high_last_s = shreg_q[39] ? 16'(ONE_HIGH_US - 1) : 16'(ZERO_HIGH_US - 1);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (tick_s) begin
      pre_d = '0;
      cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end else begin
      pre_d = pre_q + PW'(1);
      cnt_d = cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (!din_s) state_d = S_START_LOW;
        else        state_d = S_IDLE;
      end
      S_START_LOW: begin
        if (din_s) begin
          if (cnt_q >= 16'(START_MIN_US)) begin
            state_d = S_RESP_DLY;
            shreg_d = {humid_int, humid_dec, temp_int, temp_dec,
                       calc_cksum(humid_int, humid_dec, temp_int, temp_dec, cksum_err_inj)};
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_START_LOW;
        end
      end
      S_RESP_DLY: begin
        if (tick_s && cnt_q == 16'(RESP_DELAY_US - 1)) state_d = S_ACK_LOW;
        else                                            state_d = S_RESP_DLY;
      end
      S_ACK_LOW: begin
        if (tick_s && cnt_q == 16'(ACK_US - 1)) state_d = S_ACK_HIGH;
        else                                     state_d = S_ACK_LOW;
      end
      S_ACK_HIGH: begin
        if (tick_s && cnt_q == 16'(ACK_US - 1)) begin
          state_d = S_BIT_LOW;
          idx_d   = 6'd39;
        end else begin
          state_d = S_ACK_HIGH;
        end
      end
      S_BIT_LOW: begin
        // Index wraps to all-ones once the 40th bit has been sent.
        if (tick_s && cnt_q == 16'(BIT_LOW_US - 1)) begin
          if (idx_q == 6'h3F) state_d = S_DONE;
          else                state_d = S_BIT_HIGH;
        end else begin
          state_d = S_BIT_LOW;
        end
      end
      S_BIT_HIGH: begin
        if (tick_s && cnt_q == high_last_s) begin
          state_d = S_BIT_LOW;
          shreg_d = {shreg_q[38:0], 1'b0};
          idx_d   = idx_q - 6'd1;
        end else begin
          state_d = S_BIT_HIGH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      if (state_d == S_START_LOW) begin
        pre_d = SEED_PRE;
        cnt_d = SEED_CNT;
      end else begin
        pre_d = '0;
        cnt_d = '0;
      end
    end

    drive_low_d = (state_d == S_ACK_LOW) || (state_d == S_BIT_LOW);
    busy_d      = (state_d != S_IDLE) && (state_d != S_START_LOW);
    done_d      = (state_d == S_DONE);
  end

  // State, timebase, shift register and registered outputs.
  always_ff @(posedge clk_125M or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      sync_q      <= 2'b11;
      pre_q       <= '0;
      cnt_q       <= 16'd0;
      shreg_q     <= 40'd0;
      idx_q       <= 6'd0;
      drive_low_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[0], Data};
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      drive_low_q <= drive_low_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign Data       = drive_low_q ? 1'b0 : 1'bz;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
